inv_addkey_mixcol_stage: RTL

//  Registered AES decryption round back-end that sits directly downstream of invsubbytes.
//  Per accepted beat it computes AddRoundKey, then InvMixColumns; InvMixColumns is bypassed in the final round.
//  It owns the round counter and key index that select w[round] from the key store.

---
 rtl/inv_addkey_mixcol_stage_if.sv | 16 +
 rtl/inv_addkey_mixcol_stage.sv | 83 ++++++++
 2 files changed

// File: rtl/inv_addkey_mixcol_stage_if.sv
// inv_addkey_mixcol_stage_if: upstream (in_*, key_idx) and downstream (out_*) handshake bundle; slave = stage, master = environment
interface inv_addkey_mixcol_stage_if #(parameter int KIDX_W = 4);
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_data;
  logic [127:0]      in_key;
  logic [KIDX_W-1:0] key_idx;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_data;
  logic              out_last;
  modport master (output in_valid, in_data, in_key, out_ready,
                  input  in_ready, key_idx, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_data, in_key, out_ready,
                  output in_ready, key_idx, out_valid, out_data, out_last);
endinterface

// File: rtl/inv_addkey_mixcol_stage.sv
// inv_addkey_mixcol_stage: AES decrypt round back-end (AddRoundKey + InvMixColumns, bypass at round 0), round counter, 2-entry skid; ports clk, rst, bus (slave)
module inv_addkey_mixcol_stage #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input logic clk,
  input logic rst,
  inv_addkey_mixcol_stage_if.slave bus
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    // byte i takes 0e from a[i], 0b from a[i+1], 0d from a[i+2], 09 from a[i+3]
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)&3] ^ x2[(i+1)&3] ^ a[(i+1)&3])
                     ^ (x8[(i+2)&3] ^ x4[(i+2)&3] ^ a[(i+2)&3])
                     ^ (x8[(i+3)&3] ^ a[(i+3)&3]);
    return r;
  endfunction
  logic [KIDX_W-1:0] cnt;
  logic              m_v, m_l, s_v, s_l;
  logic [127:0]      m_d, s_d, x, y;
  logic              a, d, nl;
  assign a = bus.in_valid & bus.in_ready;
  assign d = m_v & bus.out_ready;
  assign nl = cnt == '0;
  always_comb begin
    x = bus.in_data ^ bus.in_key;
    y = x;
    for (int c = 0; c < 4; c++)
      y[127-32*c -: 32] = nl ? x[127-32*c -: 32] : inv_col(x[127-32*c -: 32]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= KIDX_W'(NR-1);
      m_v <= 1'b0;
      m_d <= '0;
      m_l <= 1'b0;
      s_v <= 1'b0;
      s_d <= '0;
      s_l <= 1'b0;
    end else begin
      if (a) cnt <= nl ? KIDX_W'(NR-1) : cnt - 1'b1;
      if (!m_v || d) begin
        if (s_v) begin
          m_v <= 1'b1;
          m_d <= s_d;
          m_l <= s_l;
          s_v <= 1'b0;
        end else begin
          m_v <= a;
          if (a) begin
            m_d <= y;
            m_l <= nl;
          end
        end
      end else if (a) begin
        s_v <= 1'b1;
        s_d <= y;
        s_l <= nl;
      end
    end
  end
  assign bus.in_ready  = !s_v;
  assign bus.key_idx   = cnt;
  assign bus.out_valid = m_v;
  assign bus.out_data  = m_d;
  assign bus.out_last  = m_l;
endmodule
